// File: rtl/fifo_read_stage.sv
// Read side of processor_fifo: issues pops against the pointer block, captures the
// synchronous-read RAM word and presents it through a 2-entry valid/ready buffer.
module fifo_read_stage #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  empty,
  input  logic [ADDR_WIDTH:0]   count_pop,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  pop,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            occupancy,
  output logic                  overflow_err
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e                state_q;
  logic                  in_flight_q;
  logic                  out_valid_q;
  logic                  overflow_q;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;

  logic       deq;
  logic       arrive;
  logic [1:0] pending;
  logic       unused_count_msb;

  assign deq    = out_valid_q & out_ready;
  assign arrive = in_flight_q;

  // Credit check: buffered + in-flight words, minus the one leaving now, must stay below 2.
  assign pending = 2'(state_q) + 2'(in_flight_q);
  assign pop     = rst & ~empty & (pending < (2'd2 + 2'(deq)));

  // Pointer MSB only distinguishes full from empty; the RAM address wraps on its own.
  assign rd_addr          = count_pop[ADDR_WIDTH-1:0];
  assign unused_count_msb = count_pop[ADDR_WIDTH];

  assign out_data     = head_q;
  assign out_valid    = out_valid_q;
  assign occupancy    = state_q;
  assign overflow_err = overflow_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StEmpty;
      in_flight_q <= 1'b0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      in_flight_q <= pop;
      case (state_q)
        StEmpty: begin
          if (arrive) begin
            head_q      <= rd_data;
            state_q     <= StOne;
            out_valid_q <= 1'b1;
          end
        end
        StOne: begin
          if (arrive && !deq) begin
            tail_q  <= rd_data;
            state_q <= StTwo;
          end else if (arrive && deq) begin
            head_q <= rd_data;
          end else if (deq) begin
            state_q     <= StEmpty;
            out_valid_q <= 1'b0;
          end
        end
        StTwo: begin
          if (deq) begin
            head_q <= tail_q;
            if (arrive) begin
              tail_q <= rd_data;
            end else begin
              state_q <= StOne;
            end
          end else if (arrive) begin
            // No room: drop the word and flag it until reset.
            overflow_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= StEmpty;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
